// File: rtl/test_pattern_pkg.sv
// Shared definitions for the test pattern generator: mode encodings and the
// channel replication helper used by the colour logic.
package test_pattern_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_GRID     = 3'd0;
   localparam mode_t MODE_CHECKER  = 3'd1;
   localparam mode_t MODE_BARS     = 3'd2;
   localparam mode_t MODE_GRADIENT = 3'd3;
   localparam mode_t MODE_WHITE    = 3'd4;
   localparam mode_t MODE_RED      = 3'd5;
   localparam mode_t MODE_GREEN    = 3'd6;
   localparam mode_t MODE_BLUE     = 3'd7;

   // Widest channel supported; callers narrow the result with a size cast.
   localparam int REP_MAX = 32;

   function automatic logic [REP_MAX-1:0] rep(input logic v);
      return {REP_MAX{v}};
   endfunction

endpackage

// File: rtl/test_pattern_gen_frame_ctrl.sv
// Frame bookkeeping: vsync falling-edge detect, frame counter, and the mode
// register with its optional timed auto-cycling.
module pattern_frame_ctrl
   import test_pattern_pkg::*;
#(
   parameter int FW           = 8,
   parameter int CYCLE_FRAMES = 60
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vsync_in,
   input  logic [2:0]    mode_sel,
   input  logic          auto_cycle,
   output logic [FW-1:0] frame_cnt,
   output logic [2:0]    mode_cur
);

   localparam int CCW = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
   localparam logic [CCW-1:0] CYC_LAST = CCW'(CYCLE_FRAMES - 1);

   logic           prev_vsync_q, prev_vsync_d;
   logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CCW-1:0] cyc_cnt_q, cyc_cnt_d;
   mode_t          mode_cur_q, mode_cur_d;
   logic           frame_tick;

   // prev_vsync resets low, so the first cycle after reset can never tick.
   assign frame_tick = prev_vsync_q & ~vsync_in;

   always_comb begin
      prev_vsync_d = vsync_in;
      frame_cnt_d  = frame_cnt_q;
      cyc_cnt_d    = cyc_cnt_q;
      mode_cur_d   = mode_cur_q;

      if (frame_tick) begin
         frame_cnt_d = frame_cnt_q + 1'b1;
      end

      if (!auto_cycle) begin
         cyc_cnt_d = '0;
         if (frame_tick) begin
            mode_cur_d = mode_sel;
         end
      end else if (frame_tick) begin
         if (cyc_cnt_q == CYC_LAST) begin
            cyc_cnt_d  = '0;
            mode_cur_d = mode_cur_q + 3'd1;
         end else begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_vsync_q <= 1'b0;
         frame_cnt_q  <= '0;
         cyc_cnt_q    <= '0;
         mode_cur_q   <= MODE_GRID;
      end else begin
         prev_vsync_q <= prev_vsync_d;
         frame_cnt_q  <= frame_cnt_d;
         cyc_cnt_q    <= cyc_cnt_d;
         mode_cur_q   <= mode_cur_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign mode_cur  = mode_cur_q;

endmodule

// File: rtl/test_pattern_gen.sv
// Video test pattern generator: registered colour from beam position, mode and
// frame count, with syncs delayed one cycle to stay aligned with the colour.
module test_pattern_gen
   import test_pattern_pkg::*;
#(
   parameter int XW           = 11,
   parameter int YW           = 11,
   parameter int CW           = 2,
   parameter int GRID_LOG2    = 3,
   parameter int BAR_SHIFT    = 7,
   parameter int GRAD_SHIFT   = 4,
   parameter int FW           = 8,
   parameter int CYCLE_FRAMES = 60
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [XW-1:0] hpos,
   input  logic [YW-1:0] vpos,
   input  logic          active,
   input  logic          hsync_in,
   input  logic          vsync_in,
   input  logic [2:0]    mode_sel,
   input  logic          auto_cycle,
   output logic [CW-1:0] red,
   output logic [CW-1:0] green,
   output logic [CW-1:0] blue,
   output logic          hsync_out,
   output logic          vsync_out,
   output logic [2:0]    mode_cur,
   output logic [FW-1:0] frame_cnt
);

   logic [CW-1:0] red_q, red_d;
   logic [CW-1:0] green_q, green_d;
   logic [CW-1:0] blue_q, blue_d;
   logic          hsync_q, vsync_q;
   logic [2:0]    bar_idx;
   logic          grid_line;
   logic          checker_bit;

   pattern_frame_ctrl #(
      .FW           (FW),
      .CYCLE_FRAMES (CYCLE_FRAMES)
   ) u_frame_ctrl (
      .clk        (clk),
      .rst        (rst),
      .vsync_in   (vsync_in),
      .mode_sel   (mode_sel),
      .auto_cycle (auto_cycle),
      .frame_cnt  (frame_cnt),
      .mode_cur   (mode_cur)
   );

   assign bar_idx     = hpos[BAR_SHIFT+2:BAR_SHIFT];
   assign grid_line   = (hpos[GRID_LOG2-1:0] == '0) | (vpos[GRID_LOG2-1:0] == '0);
   assign checker_bit = hpos[GRID_LOG2] ^ vpos[GRID_LOG2];

   // mode_cur is a register, so the frame_tick cycle still sees the old mode.
   always_comb begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (active) begin
         case (mode_cur)
            MODE_GRID: begin
               red_d   = CW'(rep(grid_line));
               green_d = CW'(rep(vpos[GRID_LOG2+1]));
               blue_d  = CW'(rep(hpos[GRID_LOG2+1]));
            end
            MODE_CHECKER: begin
               red_d   = CW'(rep(checker_bit));
               green_d = CW'(rep(checker_bit));
               blue_d  = CW'(rep(checker_bit));
            end
            MODE_BARS: begin
               red_d   = CW'(rep(~bar_idx[1]));
               green_d = CW'(rep(~bar_idx[2]));
               blue_d  = CW'(rep(~bar_idx[0]));
            end
            MODE_GRADIENT: begin
               // Gradient slices sit below bit XW, so the wide sum truncates identically.
               red_d   = CW'(({{FW{1'b0}}, hpos} + {{XW{1'b0}}, frame_cnt}) >> GRAD_SHIFT);
               green_d = CW'(({{FW{1'b0}}, vpos} + {{YW{1'b0}}, frame_cnt}) >> GRAD_SHIFT);
               blue_d  = frame_cnt[FW-1:FW-CW];
            end
            MODE_WHITE: begin
               red_d   = '1;
               green_d = '1;
               blue_d  = '1;
            end
            MODE_RED: begin
               red_d = '1;
            end
            MODE_GREEN: begin
               green_d = '1;
            end
            MODE_BLUE: begin
               blue_d = '1;
            end
            default: begin
               red_d   = '0;
               green_d = '0;
               blue_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         hsync_q <= hsync_in;
         vsync_q <= vsync_in;
      end
   end

   assign red       = red_q;
   assign green     = green_q;
   assign blue      = blue_q;
   assign hsync_out = hsync_q;
   assign vsync_out = vsync_q;

endmodule
